// File: rtl/bench_block_feeder.sv
// ============================================================================
// bench_block_feeder
// ----------------------------------------------------------------------------
// Upstream stage of the SHA-256 benchmark top. A start pulse snapshots the
// 64-byte base message. The block then streams 512-bit message blocks into the
// sha256 core over a valid/ready handshake. Every block carries its own
// incrementing 32-bit nonce, written big-endian into the message at
// NONCE_OFFSET. Streaming lasts BENCHMARKSECONDS seconds of wall-clock time,
// measured in fabric clock cycles. Accepted blocks are counted so the top can
// report hash throughput.
//
// Parameters
//   CLK_HZ            clk frequency in Hz (one second = CLK_HZ cycles), >= 1
//   BENCHMARKSECONDS  run length in seconds, 0..600
//   NONCE_OFFSET      byte offset of the nonce in the block, multiple of 4, <= 60
//
// Ports
//   clk            in   1      clock
//   resetn         in   1      asynchronous, active-low reset
//   start          in   1      single-cycle start request (ignored while busy)
//   input_buffer   in   8x64   base message, byte 0 first
//   block_valid    out  1      block_data / block_nonce are valid
//   block_ready    in   1      sha256 core accepts the current block
//   block_data     out  512    message block, byte 0 in [511:504]
//   block_nonce    out  32     nonce embedded in the current block_data
//   busy           out  1      high while streaming or draining
//   done           out  1      high once the run has finished
//   blocks_issued  out  32     accepted-block count for the current run
// ============================================================================
module bench_block_feeder #(
    parameter int CLK_HZ           = 12_000_000,
    parameter int BENCHMARKSECONDS = 10,
    parameter int NONCE_OFFSET     = 60
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [7:0]   input_buffer [0:63],
    output logic         block_valid,
    input  logic         block_ready,
    output logic [511:0] block_data,
    output logic [31:0]  block_nonce,
    output logic         busy,
    output logic         done,
    output logic [31:0]  blocks_issued
);

    // Bad parameters are rejected at elaboration. Otherwise they would give a
    // timer that never expires or a nonce slice that falls outside the block.
    if (CLK_HZ < 1) begin : gBadClkHz
        $fatal(1, "bench_block_feeder: CLK_HZ must be >= 1 (got %0d)", CLK_HZ);
    end
    if (BENCHMARKSECONDS < 0 || BENCHMARKSECONDS > 600) begin : gBadSeconds
        $fatal(1, "bench_block_feeder: BENCHMARKSECONDS must be 0..600 (got %0d)",
               BENCHMARKSECONDS);
    end
    if (NONCE_OFFSET < 0 || NONCE_OFFSET > 60 || (NONCE_OFFSET % 4) != 0) begin : gBadOffset
        $fatal(1, "bench_block_feeder: NONCE_OFFSET must be a multiple of 4 in 0..60 (got %0d)",
               NONCE_OFFSET);
    end

    // The tick counter needs at least one bit, even when CLK_HZ is 1. The
    // seconds counter is sized for the largest run (600 s). On expiry it steps
    // one past the last second, and 10 bits still hold that value.
    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SEC_W  = 10;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  =
        SEC_W'((BENCHMARKSECONDS > 0) ? (BENCHMARKSECONDS - 1) : 0);

    // Bit position of the nonce MSB inside the packed block (byte 0 at the top).
    localparam int NONCE_MSB = 511 - 8 * NONCE_OFFSET;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feederState_e;

    feederState_e       state_q;
    logic               blockValid_q;
    logic               busy_q;
    logic               done_q;
    logic [511:0]       snapshot_q;
    logic [31:0]        nonce_q;
    logic [31:0]        blocksIssued_q;
    logic [TICK_W-1:0]  tick_q;
    logic [SEC_W-1:0]   sec_q;

    logic [511:0]       snapshot_d;
    logic [31:0]        nonce_d;
    logic [31:0]        blocksIssued_d;
    logic [TICK_W-1:0]  tick_d;
    logic [SEC_W-1:0]   sec_d;

    logic               transfer;
    logic               tickWrap;
    logic               expiry;
    logic [511:0]       blockData;

    // Pack the byte array so that byte 0 lands in the top byte of the block.
    always_comb begin
        snapshot_d = '0;
        for (int i = 0; i < 64; i++) begin
            snapshot_d[511 - 8 * i -: 8] = input_buffer[i];
        end
    end

    // Handshake, timer and counter next-state values.
    // The nonce wraps naturally. The issued count saturates so that a very
    // long run never reports a small number.
    always_comb begin
        transfer       = blockValid_q & block_ready;
        tickWrap       = (tick_q == TICK_LAST);
        expiry         = (state_q == RUN) && tickWrap && (sec_q == SEC_LAST);
        nonce_d        = nonce_q + 32'd1;
        blocksIssued_d = (blocksIssued_q == 32'hFFFF_FFFF) ? blocksIssued_q
                                                           : blocksIssued_q + 32'd1;
        tick_d         = tickWrap ? '0 : tick_q + 1'b1;
        sec_d          = tickWrap ? sec_q + 1'b1 : sec_q;
    end

    // The outgoing block is the frozen snapshot with the nonce written in
    // big-endian at NONCE_OFFSET. Both sources are registers, so the block
    // only changes when the nonce advances after a transfer, or when a start
    // takes a new snapshot.
    always_comb begin
        blockData                    = snapshot_q;
        blockData[NONCE_MSB -: 32]   = nonce_q;
    end

    // Control FSM. All flag outputs are registered alongside the state.
    //
    // Once block_valid is raised it is never dropped without a transfer. If
    // the timer expires while the core is stalling, the FSM parks in DRAIN
    // with the timer frozen until the pending block is taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            blockValid_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            snapshot_q     <= '0;
            nonce_q        <= '0;
            blocksIssued_q <= '0;
            tick_q         <= '0;
            sec_q          <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        snapshot_q     <= snapshot_d;
                        nonce_q        <= '0;
                        blocksIssued_q <= '0;
                        tick_q         <= '0;
                        sec_q          <= '0;
                        if (BENCHMARKSECONDS == 0) begin
                            // A zero-length run finishes at once and never offers a block.
                            state_q      <= DONE;
                            blockValid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            state_q      <= RUN;
                            blockValid_q <= 1'b1;
                            busy_q       <= 1'b1;
                            done_q       <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    tick_q <= tick_d;
                    sec_q  <= sec_d;
                    if (transfer) begin
                        nonce_q        <= nonce_d;
                        blocksIssued_q <= blocksIssued_d;
                    end
                    if (expiry) begin
                        if (transfer) begin
                            state_q      <= DONE;
                            blockValid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            state_q      <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (transfer) begin
                        nonce_q        <= nonce_d;
                        blocksIssued_q <= blocksIssued_d;
                        state_q        <= DONE;
                        blockValid_q   <= 1'b0;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                    end
                end

                default: begin
                    state_q      <= IDLE;
                    blockValid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign block_valid   = blockValid_q;
    assign block_data    = blockData;
    assign block_nonce   = nonce_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign blocks_issued = blocksIssued_q;

    // A stalled block must remain offered and unchanged in the next cycle.
    stalledBlockHeld: assert property (
        @(posedge clk) disable iff (!resetn)
        (blockValid_q && !block_ready) |=> (blockValid_q && $stable(nonce_q) && $stable(snapshot_q))
    );

    // done and busy are mutually exclusive, and nothing is offered once done.
    doneIsQuiet: assert property (
        @(posedge clk) disable iff (!resetn)
        done_q |-> (!busy_q && !blockValid_q)
    );

endmodule

// File: tb/tb_bench_block_feeder.sv
// ============================================================================
// tb_bench_block_feeder
// ----------------------------------------------------------------------------
// Bench for bench_block_feeder with a short timer (CLK_HZ=100, 2 s, so a
// 200-cycle run), plus a second instance configured for a zero-length run.
// Expected blocks (nonce + full 512-bit data) are queued when a run is started
// and checked against every cycle the DUT offers a block.
// ============================================================================
module tb_bench_block_feeder;

    localparam int CLK_HZ     = 100;
    localparam int SECONDS    = 2;
    localparam int RUN_CYCLES = CLK_HZ * SECONDS;

    typedef struct {
        logic [31:0]  nonce;
        logic [511:0] data;
    } expBlock_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         blockReady;
    logic [7:0]   inputBuf [0:63];
    logic [7:0]   modelBuf [0:63];

    logic         blockValid;
    logic [511:0] blockData;
    logic [31:0]  blockNonce;
    logic         busy;
    logic         done;
    logic [31:0]  blocksIssued;

    logic         startZero;
    logic         readyZero;
    logic         blockValidZero;
    logic [511:0] blockDataZero;
    logic [31:0]  blockNonceZero;
    logic         busyZero;
    logic         doneZero;
    logic [31:0]  blocksIssuedZero;

    expBlock_t    expQ [$];
    int           checkCount    = 0;
    int           failCount     = 0;
    int           validCycles   = 0;
    int           transfers     = 0;
    logic [31:0]  lastNonce     = '0;
    logic         zeroValidSeen = 1'b0;

    always #5 clk = ~clk;

    bench_block_feeder #(
        .CLK_HZ           (CLK_HZ),
        .BENCHMARKSECONDS (SECONDS),
        .NONCE_OFFSET     (60)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .input_buffer  (inputBuf),
        .block_valid   (blockValid),
        .block_ready   (blockReady),
        .block_data    (blockData),
        .block_nonce   (blockNonce),
        .busy          (busy),
        .done          (done),
        .blocks_issued (blocksIssued)
    );

    bench_block_feeder #(
        .CLK_HZ           (CLK_HZ),
        .BENCHMARKSECONDS (0),
        .NONCE_OFFSET     (60)
    ) dutZero (
        .clk           (clk),
        .resetn        (resetn),
        .start         (startZero),
        .input_buffer  (inputBuf),
        .block_valid   (blockValidZero),
        .block_ready   (readyZero),
        .block_data    (blockDataZero),
        .block_nonce   (blockNonceZero),
        .busy          (busyZero),
        .done          (doneZero),
        .blocks_issued (blocksIssuedZero)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [511:0] actual,
                               input logic [511:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference block: the base message byte by byte, with bytes 60..63
    // taken from the nonce MSB first.
    function automatic logic [511:0] blockModel(input logic [31:0] n);
        logic [511:0] acc;
        logic [7:0]   b;
        acc = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= 60) b = n[8 * (63 - i) +: 8];
            else         b = modelBuf[i];
            acc = {acc[503:0], b};
        end
        return acc;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents modelBuf, queues the blocks the run should deliver, and pulses start.
    // On return the bench sits in the first cycle of the run.
    task automatic applyStimulus(input int nBlocks);
        for (int i = 0; i < 64; i++) inputBuf[i] = modelBuf[i];
        expQ.delete();
        for (int n = 0; n < nBlocks; n++) begin
            expBlock_t e;
            e.nonce = 32'(n);
            e.data  = blockModel(32'(n));
            expQ.push_back(e);
        end
        validCycles = 0;
        transfers   = 0;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
    endtask

    task automatic randomBuffer();
        for (int i = 0; i < 64; i++) modelBuf[i] = 8'($urandom_range(0, 255));
    endtask

    // Scoreboard monitor, sampled mid-cycle. Every offered block (stalled or
    // accepted) must match the head of the queue. The head is retired on a transfer.
    always @(negedge clk) begin
        if (resetn && blockValid) begin
            validCycles++;
            checkOutput("sbDepth", 512'(expQ.size() > 0), 512'(1));
            if (expQ.size() > 0) begin
                checkOutput("blockNonce", 512'(blockNonce), 512'(expQ[0].nonce));
                checkOutput("blockData", blockData, expQ[0].data);
                if (blockReady) begin
                    lastNonce = blockNonce;
                    void'(expQ.pop_front());
                    transfers++;
                end
            end
        end
        if (blockValidZero) zeroValidSeen = 1'b1;
    end

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        blockReady = 1'b0;
        startZero  = 1'b0;
        readyZero  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            inputBuf[i] = 8'h00;
            modelBuf[i] = 8'h00;
        end

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", 512'(blockValid), 512'(0));
        checkOutput("rstBusy", 512'(busy), 512'(0));
        checkOutput("rstDone", 512'(done), 512'(0));
        checkOutput("rstIssued", 512'(blocksIssued), 512'(0));
        checkOutput("rstNonce", 512'(blockNonce), 512'(0));
        checkOutput("rstData", blockData, 512'(0));
        resetn = 1'b1;
        stepCycle();

        // ---- zero-length run ----
        startZero = 1'b1;
        stepCycle();
        startZero = 1'b0;
        checkOutput("zeroDone", 512'(doneZero), 512'(1));
        checkOutput("zeroValid", 512'(blockValidZero), 512'(0));
        checkOutput("zeroBusy", 512'(busyZero), 512'(0));
        checkOutput("zeroIssued", 512'(blocksIssuedZero), 512'(0));

        // ---- free run, always ready, base message bytes 0..63 ----
        for (int i = 0; i < 64; i++) modelBuf[i] = 8'(i);
        applyStimulus(RUN_CYCLES);
        checkOutput("freeBusy", 512'(busy), 512'(1));
        checkOutput("freeValid", 512'(blockValid), 512'(1));
        for (int k = 0; k < RUN_CYCLES; k++) begin
            blockReady = 1'b1;
            if (k == 0) begin
                checkOutput("placeFirstLow", 512'(blockData[31:0]), 512'(32'h0000_0000));
                checkOutput("placeFirstHigh", 512'(blockData[511:480]), 512'(32'h0001_0203));
            end
            if (k == 1) begin
                checkOutput("placeSecondLow", 512'(blockData[31:0]), 512'(32'h0000_0001));
            end
            stepCycle();
        end
        blockReady = 1'b0;
        checkOutput("freeDone", 512'(done), 512'(1));
        checkOutput("freeBusyEnd", 512'(busy), 512'(0));
        checkOutput("freeValidEnd", 512'(blockValid), 512'(0));
        checkOutput("freeIssued", 512'(blocksIssued), 512'(200));
        checkOutput("freeValidCycles", 512'(validCycles), 512'(200));
        checkOutput("freeLastNonce", 512'(lastNonce), 512'(32'h0000_00C7));
        checkOutput("freeSbEmpty", 512'(expQ.size()), 512'(0));

        // ---- backpressure 1,0,1,0..., start ignored mid-run, input changed after snapshot ----
        randomBuffer();
        applyStimulus(101);
        checkOutput("bpRestartIssued", 512'(blocksIssued), 512'(0));
        checkOutput("bpRestartDone", 512'(done), 512'(0));
        for (int k = 0; k < RUN_CYCLES; k++) begin
            blockReady = (k % 2 == 0);
            start      = (k == 51);
            if (k == 10) begin
                for (int i = 0; i < 64; i++) inputBuf[i] = ~modelBuf[i];
            end
            stepCycle();
        end
        start = 1'b0;
        checkOutput("bpDrainValid", 512'(blockValid), 512'(1));
        checkOutput("bpDrainBusy", 512'(busy), 512'(1));
        checkOutput("bpDrainDone", 512'(done), 512'(0));
        checkOutput("bpIssued", 512'(blocksIssued), 512'(100));
        checkOutput("bpNonce", 512'(blockNonce), 512'(100));
        checkOutput("bpValidCycles", 512'(validCycles), 512'(200));
        blockReady = 1'b1;
        stepCycle();
        blockReady = 1'b0;
        checkOutput("bpDone", 512'(done), 512'(1));
        checkOutput("bpBusyEnd", 512'(busy), 512'(0));
        checkOutput("bpIssuedEnd", 512'(blocksIssued), 512'(101));
        checkOutput("bpTransfers", 512'(transfers), 512'(101));
        checkOutput("bpSbEmpty", 512'(expQ.size()), 512'(0));

        // ---- drain: ready low for cycles 195..209, single transfer at 210 ----
        randomBuffer();
        applyStimulus(196);
        checkOutput("drainRestartIssued", 512'(blocksIssued), 512'(0));
        checkOutput("drainRestartBusy", 512'(busy), 512'(1));
        for (int k = 0; k <= 210; k++) begin
            blockReady = (k < 195) || (k >= 210);
            if (k == 205) begin
                checkOutput("drainMidValid", 512'(blockValid), 512'(1));
                checkOutput("drainMidBusy", 512'(busy), 512'(1));
                checkOutput("drainMidDone", 512'(done), 512'(0));
                checkOutput("drainMidIssued", 512'(blocksIssued), 512'(195));
                checkOutput("drainMidNonce", 512'(blockNonce), 512'(195));
            end
            stepCycle();
        end
        blockReady = 1'b0;
        checkOutput("drainDone", 512'(done), 512'(1));
        checkOutput("drainValidEnd", 512'(blockValid), 512'(0));
        checkOutput("drainIssued", 512'(blocksIssued), 512'(196));
        checkOutput("drainValidCycles", 512'(validCycles), 512'(211));
        checkOutput("drainSbEmpty", 512'(expQ.size()), 512'(0));

        // ---- asynchronous reset in the middle of a run ----
        randomBuffer();
        applyStimulus(RUN_CYCLES);
        for (int k = 0; k < 50; k++) begin
            blockReady = 1'b1;
            stepCycle();
        end
        checkOutput("midIssued", 512'(blocksIssued), 512'(50));
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("asyncValid", 512'(blockValid), 512'(0));
        checkOutput("asyncBusy", 512'(busy), 512'(0));
        checkOutput("asyncDone", 512'(done), 512'(0));
        checkOutput("asyncIssued", 512'(blocksIssued), 512'(0));
        checkOutput("asyncNonce", 512'(blockNonce), 512'(0));
        checkOutput("asyncData", blockData, 512'(0));
        checkOutput("asyncZeroDone", 512'(doneZero), 512'(0));
        expQ.delete();
        blockReady = 1'b0;
        stepCycle();
        resetn = 1'b1;
        stepCycle();
        checkOutput("idleValid", 512'(blockValid), 512'(0));
        checkOutput("idleBusy", 512'(busy), 512'(0));
        checkOutput("idleDone", 512'(done), 512'(0));

        checkOutput("zeroNeverValid", 512'(zeroValidSeen), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
